// File: rtl/tx_sched_pkg.sv
// Shared definitions for the TX FIFO scheduler: FSM state encodings and sizing helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_sched_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arbState_t;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_POP     = 2'd1,
    D_WAIT_HI = 2'd2,
    D_WAIT_LO = 2'd3
  } drainState_t;

  localparam int BUSY_TIMEOUT_DEF = 4096;

  // Width of a requester index; never narrower than one bit.
  function automatic int calcGrantW(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo_scheduler_rr_select.sv
// Round-robin winner select: first valid index searching upward from iPtr+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; oAny=0 when no request is valid.
// Ports: iValid (request vector), iPtr (last served) -> oIdx (winner), oAny (any valid).
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] iValid,
  input  logic [IDX_W-1:0]   iPtr,
  output logic [IDX_W-1:0]   oIdx,
  output logic               oAny
);

  logic [IDX_W-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    oIdx = '0;
    oAny = 1'b0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(iPtr) + i) % NUM_REQ);
      if (iValid[cand]) begin
        oAny = 1'b1;
        oIdx = cand;
      end
    end
  end

endmodule

// File: rtl/tx_fifo_scheduler.sv
// Shares the UART TX FIFO among NUM_REQ packet requesters and drains it one byte per TX frame.
// Latency: grant 1 clk after arbitration, push path combinational; pop pulse 1 clk after idle conditions.
// Backpressure: iFifoFull drops the granted ready bit; iTxBusy/iEnable/iFifoEmpty hold off pops.
// Ports: iReq*/oReqReady requester side, oPush*/iFifoFull/iFifoEmpty FIFO side, iTxBusy/oPopValid
//        serializer side, oGrantValid/oGrantId/oPopCnt/oTimeout status.
module tx_fifo_scheduler
  import tx_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter  int CNT_W        = 16,
  localparam int GRANT_W      = calcGrantW(NUM_REQ)
) (
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic [NUM_REQ-1:0]   iReqValid,
  input  logic [NUM_REQ*8-1:0] iReqData,
  input  logic [NUM_REQ-1:0]   iReqLast,
  output logic [NUM_REQ-1:0]   oReqReady,
  output logic                 oPushValid,
  output logic [7:0]           oPushData,
  input  logic                 iFifoFull,
  input  logic                 iFifoEmpty,
  input  logic                 iTxBusy,
  output logic                 oPopValid,
  input  logic                 iEnable,
  output logic                 oGrantValid,
  output logic [GRANT_W-1:0]   oGrantId,
  output logic [CNT_W-1:0]     oPopCnt,
  output logic                 oTimeout
);

  localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  // ---------------- push-side arbiter ----------------
  arbState_t          arbState, arbNext;
  logic [GRANT_W-1:0] grantId, rrPtr, winIdx;
  logic               winAny, pushFire, pushLast;
  logic [7:0]         reqByte [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : gSlice
    assign reqByte[k] = iReqData[8*k +: 8];
  end

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(GRANT_W)) uRrSelect (
    .iValid (iReqValid),
    .iPtr   (rrPtr),
    .oIdx   (winIdx),
    .oAny   (winAny)
  );

  assign pushFire = (arbState == ARB_GRANT) & iReqValid[grantId] & ~iFifoFull;
  assign pushLast = pushFire & iReqLast[grantId];

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) arbState <= ARB_IDLE;
    else        arbState <= arbNext;
  end

  always_comb begin
    arbNext = arbState;
    unique case (arbState)
      ARB_IDLE:  if (winAny)   arbNext = ARB_GRANT;
      ARB_GRANT: if (pushLast) arbNext = ARB_IDLE;
      default:                 arbNext = ARB_IDLE;
    endcase
  end

  // Pointer starts at the top index so requester 0 is first after reset.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      grantId <= '0;
      rrPtr   <= GRANT_W'(NUM_REQ - 1);
    end else begin
      if (arbState == ARB_IDLE && winAny) grantId <= winIdx;
      if (pushLast)                       rrPtr   <= grantId;
    end
  end

  always_comb begin
    oGrantValid = (arbState == ARB_GRANT);
    oGrantId    = grantId;
    oReqReady   = '0;
    oPushValid  = pushFire;
    oPushData   = '0;
    if (arbState == ARB_GRANT) begin
      oReqReady[grantId] = ~iFifoFull;
      oPushData          = reqByte[grantId];
    end
  end

  // ---------------- pop-side drain sequencer ----------------
  drainState_t     dState, dNext;
  logic [TO_W-1:0] toCnt;
  logic            toHit;

  assign toHit = (dState == D_WAIT_HI) & ~iTxBusy & (toCnt == TO_LAST);

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) dState <= D_IDLE;
    else        dState <= dNext;
  end

  always_comb begin
    dNext = dState;
    unique case (dState)
      D_IDLE:    if (iEnable && !iFifoEmpty && !iTxBusy) dNext = D_POP;
      D_POP:     dNext = D_WAIT_HI;
      D_WAIT_HI: if (iTxBusy) dNext = D_WAIT_LO;
                 else if (toCnt == TO_LAST) dNext = D_IDLE;
      D_WAIT_LO: if (!iTxBusy) dNext = D_IDLE;
      default:   dNext = D_IDLE;
    endcase
  end

  // Timeout counter is zeroed during the pop pulse so it starts fresh in D_WAIT_HI.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      toCnt    <= '0;
      oPopCnt  <= '0;
      oTimeout <= 1'b0;
    end else begin
      if (dState == D_POP) begin
        toCnt   <= '0;
        oPopCnt <= oPopCnt + CNT_W'(1);
      end else if (dState == D_WAIT_HI && !iTxBusy && !toHit) begin
        toCnt <= toCnt + TO_W'(1);
      end
      if (toHit) oTimeout <= 1'b1;
    end
  end

  always_comb begin
    oPopValid = (dState == D_POP);
  end

endmodule

// File: tb/tb_tx_fifo_scheduler.sv
// Bench for tx_fifo_scheduler with behavioural FIFO, serializer and requester models.
// Latency: n/a.
// Backpressure: FIFO full/empty and serializer busy come from the queue-based environment.
module tb_tx_fifo_scheduler;
  import tx_sched_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int CNT_W        = 16;
  localparam int GRANT_W      = calcGrantW(NUM_REQ);

  logic                 iClk = 1'b0;
  logic                 iRstn;
  logic [NUM_REQ-1:0]   iReqValid, iReqLast, oReqReady;
  logic [NUM_REQ*8-1:0] iReqData;
  logic                 oPushValid, iFifoFull, iFifoEmpty, iTxBusy, oPopValid, iEnable;
  logic [7:0]           oPushData;
  logic                 oGrantValid, oTimeout;
  logic [GRANT_W-1:0]   oGrantId;
  logic [CNT_W-1:0]     oPopCnt;

  always #5 iClk = ~iClk;

  tx_fifo_scheduler #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRstn(iRstn), .iReqValid(iReqValid), .iReqData(iReqData), .iReqLast(iReqLast),
    .oReqReady(oReqReady), .oPushValid(oPushValid), .oPushData(oPushData), .iFifoFull(iFifoFull),
    .iFifoEmpty(iFifoEmpty), .iTxBusy(iTxBusy), .oPopValid(oPopValid), .iEnable(iEnable),
    .oGrantValid(oGrantValid), .oGrantId(oGrantId), .oPopCnt(oPopCnt), .oTimeout(oTimeout)
  );

  // Environment: requester byte queues (bit 8 = last), FIFO contents, serializer frame.
  logic [8:0] reqQ [NUM_REQ][$];
  logic [7:0] fifoQ[$], txLog[$], expOrder[$];
  int         grantLog[$], expGrants[$];
  bit         inPkt [NUM_REQ];
  int         fifoDepth;
  bit         gapEn, enRand, tieLow, enDrv;
  bit         serActive;
  int         serT, serDelay, serLen;
  // Reference arbiter state: which requester should hold the grant.
  bit         mBusy;
  int         mGid, mPtr;
  bit         prevGv, prevPop, prevEn, busyD1, busyD2;
  int         popPulses;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    logic [NUM_REQ*8-1:0] d;
    d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      iReqValid[k] = 1'b0;
      iReqLast[k]  = 1'b0;
      d = d << 8;
      if (reqQ[k].size() > 0) begin
        iReqValid[k] = !(gapEn && inPkt[k] && $urandom_range(0, 3) == 0);
        iReqLast[k]  = reqQ[k][0][8];
        d[7:0]       = reqQ[k][0][7:0];
      end
    end
    iReqData   = d;
    iFifoFull  = (fifoQ.size() >= fifoDepth);
    iFifoEmpty = (fifoQ.size() == 0);
    iTxBusy    = serActive && (serT >= serDelay) && (serT < serDelay + serLen);
    iEnable    = enRand ? ($urandom_range(0, 4) != 0) : enDrv;
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] expReady;
    logic               expPush;
    logic [7:0]         expData;
    logic [8:0]         b9;
    bit                 found;
    int                 k;
    @(negedge iClk);
    expPush  = mBusy && iReqValid[mGid] && !iFifoFull;
    expReady = '0;
    expData  = 8'h00;
    if (mBusy && !iFifoFull) expReady[mGid] = 1'b1;
    if (expPush) expData = reqQ[mGid][0][7:0];
    chk("grant_vld", oGrantValid, mBusy);
    if (mBusy) chk("grant_id", oGrantId, mGid);
    chk("req_rdy", oReqReady, expReady);
    chk("push_vld", oPushValid, expPush);
    if (expPush) chk("push_dat", oPushData, expData);
    if (oGrantValid && !prevGv) grantLog.push_back(int'(oGrantId));
    if (oPopValid) begin
      popPulses++;
      chk("pop_nonempty", fifoQ.size() > 0, 1);
      chk("pop_frame_idle", serActive, 0);
      chk("pop_one_clk", prevPop, 0);
      chk("pop_enable", prevEn, 1);
      chk("pop_busy_gap", {busyD2, busyD1}, 0);
    end
    // environment reacts to the DUT at the coming edge
    for (int r = 0; r < NUM_REQ; r++)
      if (iReqValid[r] && oReqReady[r]) begin
        b9 = reqQ[r].pop_front();
        inPkt[r] = !b9[8];
      end
    if (oPopValid && fifoQ.size() > 0) begin
      txLog.push_back(fifoQ.pop_front());
      if (!tieLow) begin
        serActive = 1'b1;
        serT      = 0;
        serDelay  = $urandom_range(1, 3);
        serLen    = $urandom_range(2, 6);
      end
    end
    if (oPushValid && !iFifoFull) fifoQ.push_back(oPushData);
    // reference arbiter advances
    if (!mBusy) begin
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (mPtr + i) % NUM_REQ;
        if (!found && iReqValid[k]) begin
          found = 1'b1;
          mBusy = 1'b1;
          mGid  = k;
        end
      end
    end else if (expPush && iReqLast[mGid]) begin
      mBusy = 1'b0;
      mPtr  = mGid;
    end
    prevGv  = oGrantValid;
    prevPop = oPopValid;
    prevEn  = iEnable;
    busyD2  = busyD1;
    busyD1  = iTxBusy;
    @(posedge iClk);
    #1;
    if (serActive) begin
      serT++;
      if (serT >= serDelay + serLen) serActive = 1'b0;
    end
    drive();
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_rdy"}, oReqReady, 0);
    chk({tag, "_push"}, {oPushValid, oPushData}, 0);
    chk({tag, "_pop"}, oPopValid, 0);
    chk({tag, "_grant"}, {oGrantValid, oGrantId}, 0);
    chk({tag, "_popcnt"}, oPopCnt, 0);
    chk({tag, "_timeout"}, oTimeout, 0);
  endtask

  task automatic doReset();
    iRstn = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      reqQ[k].delete();
      inPkt[k] = 1'b0;
    end
    fifoQ.delete(); txLog.delete(); expOrder.delete(); grantLog.delete(); expGrants.delete();
    serActive = 0; serT = 0; serDelay = 1; serLen = 1;
    mBusy = 0; mGid = 0; mPtr = NUM_REQ - 1;
    prevGv = 0; prevPop = 0; prevEn = 0; busyD1 = 0; busyD2 = 0; popPulses = 0;
    gapEn = 0; enRand = 0; tieLow = 0; enDrv = 0; fifoDepth = 8;
    drive();
    repeat (2) @(posedge iClk);
    #1;
    chkAllZero("rst");
    iRstn = 1'b1;
  endtask

  task automatic loadPkt(input int k, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) reqQ[k].push_back({i == len - 1, base + 8'(i)});
  endtask

  // Whole-run expectation: packets served in round-robin order among pending requesters.
  task automatic computeExpect();
    logic [8:0] tmp [NUM_REQ][$];
    logic [8:0] b;
    int         last, k;
    bit         found;
    for (int r = 0; r < NUM_REQ; r++) tmp[r] = reqQ[r];
    last = mPtr;
    do begin
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (last + i) % NUM_REQ;
        if (!found && tmp[k].size() > 0) begin
          found = 1'b1;
          expGrants.push_back(k);
          last = k;
          do begin
            b = tmp[k].pop_front();
            expOrder.push_back(b[7:0]);
          end while (!b[8] && tmp[k].size() > 0);
        end
      end
    end while (found);
    drive();
  endtask

  task automatic runUntilDone(input int budget, input string tag);
    int  n;
    bit  busyEnv;
    n = 0;
    busyEnv = 1'b1;
    while (busyEnv && n < budget) begin
      step();
      n++;
      busyEnv = mBusy || serActive || fifoQ.size() > 0;
      for (int k = 0; k < NUM_REQ; k++) if (reqQ[k].size() > 0) busyEnv = 1'b1;
    end
    chk({tag, "_done"}, n < budget, 1);
  endtask

  task automatic checkOrder(input string tag);
    chk({tag, "_byte_count"}, txLog.size(), expOrder.size());
    for (int i = 0; i < txLog.size() && i < expOrder.size(); i++)
      chk({tag, "_byte"}, txLog[i], expOrder[i]);
    chk({tag, "_grant_count"}, grantLog.size(), expGrants.size());
    for (int i = 0; i < grantLog.size() && i < expGrants.size(); i++)
      chk({tag, "_grant_seq"}, grantLog[i], expGrants[i]);
  endtask

  initial begin
    int n;
    // reset and idle
    doReset();
    repeat (3) step();
    chkAllZero("idle");

    // req1 packet of three bytes while req2 waits
    doReset();
    gapEn = 1; enDrv = 1;
    loadPkt(1, 3, 8'hA0);
    loadPkt(2, 2, 8'hB0);
    computeExpect();
    runUntilDone(400, "t2");
    checkOrder("t2");
    if (grantLog.size() >= 2) begin
      chk("t2_first_grant", grantLog[0], 1);
      chk("t2_second_grant", grantLog[1], 2);
    end else chk("t2_grants_seen", grantLog.size(), 2);

    // all requesters contending with single-byte packets
    doReset();
    enDrv = 1;
    for (int k = 0; k < NUM_REQ; k++) begin
      loadPkt(k, 1, 8'(8'h10 * k));
      loadPkt(k, 1, 8'(8'h10 * k + 1));
    end
    computeExpect();
    runUntilDone(800, "t3");
    checkOrder("t3");
    if (grantLog.size() >= 5) begin
      chk("t3_g0", grantLog[0], 0);
      chk("t3_g4", grantLog[4], 0);
    end else chk("t3_grants_seen", grantLog.size(), 8);

    // FIFO fills mid-packet
    doReset();
    fifoDepth = 4;
    loadPkt(0, 7, 8'h40);
    computeExpect();
    repeat (20) step();
    chk("t4_fifo_level", fifoQ.size(), 4);
    chk("t4_rdy0", oReqReady[0], 0);
    chk("t4_hold_grant", oGrantValid, 1);
    chk("t4_no_push", oPushValid, 0);
    enDrv = 1;
    runUntilDone(600, "t4");
    checkOrder("t4");

    // drain five queued bytes
    doReset();
    loadPkt(3, 5, 8'h50);
    computeExpect();
    repeat (15) step();
    chk("t5_queued", fifoQ.size(), 5);
    chk("t5_no_pop_disabled", popPulses, 0);
    enDrv = 1;
    runUntilDone(500, "t5");
    chk("t5_pops", popPulses, 5);
    chk("t5_popcnt", oPopCnt, 5);
    chk("t5_empty", fifoQ.size(), 0);
    checkOrder("t5");

    // serializer never goes busy
    doReset();
    tieLow = 1; enDrv = 1;
    loadPkt(1, 2, 8'h60);
    computeExpect();
    n = 0;
    while (oPopValid !== 1'b1 && n < 100) begin step(); n++; end
    chk("t6_pop_seen", n < 100, 1);
    repeat (BUSY_TIMEOUT) step();
    chk("t6_timeout_early", oTimeout, 0);
    step();
    chk("t6_timeout_set", oTimeout, 1);
    step();
    chk("t6_next_pop", oPopValid, 1);
    runUntilDone(200, "t6");
    repeat (20) step();
    chk("t6_popcnt", oPopCnt, 2);
    chk("t6_timeout_sticky", oTimeout, 1);
    checkOrder("t6");

    // asynchronous reset in the middle of a frame
    doReset();
    enDrv = 1;
    loadPkt(2, 3, 8'h70);
    computeExpect();
    n = 0;
    while (oPopValid !== 1'b1 && n < 100) begin step(); n++; end
    chk("t7_pop_seen", n < 100, 1);
    #2 iRstn = 1'b0;
    #1;
    chkAllZero("t7_async");
    doReset();
    repeat (3) step();

    // randomized traffic
    for (int r = 0; r < 3; r++) begin
      doReset();
      gapEn = 1; enRand = 1;
      fifoDepth = $urandom_range(2, 6);
      for (int k = 0; k < NUM_REQ; k++)
        for (int p = $urandom_range(0, 3); p > 0; p--)
          loadPkt(k, $urandom_range(1, 5), 8'($urandom_range(0, 255)));
      computeExpect();
      runUntilDone(4000, "rand");
      checkOrder("rand");
      chk("rand_popcnt", oPopCnt, expOrder.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
